// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet accelerator layer sequencer:
// layer indices, layer count and the sequencer state encoding.
package lenet_pkg;

    localparam int NUM_LAYERS = 5;

    localparam int L_CONV1 = 0;
    localparam int L_POOL1 = 1;
    localparam int L_CONV2 = 2;
    localparam int L_POOL2 = 3;
    localparam int L_FC    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_GAP,
        S_DONE,
        S_ERR
    } seq_state_t;

endpackage

// File: rtl/lenet_layer_wdog.sv
// Per-layer RUN cycle counter with saturation and a timeout compare.
// The count restarts from zero whenever i_clear is high.
module lenet_layer_wdog #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_run && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt     = r_cnt;
    assign o_expired = i_run && (r_cnt == i_limit);

endmodule

// File: rtl/lenet_layer_seq.sv
// Layer scheduler: resets, enables and waits on each engine in turn,
// with per-layer cycle count, watchdog timeout and abort.
module lenet_layer_seq
    import lenet_pkg::*;
#(
    parameter int               NUM_LAYERS = lenet_pkg::NUM_LAYERS,
    parameter int               IDX_W      = 3,
    parameter int               RST_CYCLES = 2,
    parameter int               CNT_W      = 20,
    parameter logic [CNT_W-1:0] TIMEOUT    = 20'hF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic [NUM_LAYERS-1:0] layer_rst,
    output logic [IDX_W-1:0]      cur_layer,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [IDX_W-1:0]      err_layer,
    output logic [CNT_W-1:0]      last_cycles
);

    localparam int               RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(L_CONV1);

    seq_state_t             r_state;
    logic [RST_W-1:0]       r_rst_cnt;
    logic [IDX_W-1:0]       r_cur_layer;
    logic [NUM_LAYERS-1:0]  r_layer_en;
    logic [NUM_LAYERS-1:0]  r_layer_rst;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;
    logic [IDX_W-1:0]       r_err_layer;
    logic [CNT_W-1:0]       r_last_cycles;

    seq_state_t             w_state_next;
    logic [RST_W-1:0]       w_rst_cnt_next;
    logic [IDX_W-1:0]       w_cur_next;
    logic [NUM_LAYERS-1:0]  w_sel_next;
    logic [NUM_LAYERS-1:0]  w_layer_en_next;
    logic [NUM_LAYERS-1:0]  w_layer_rst_next;
    logic                   w_busy_next;
    logic                   w_done_next;
    logic                   w_error_next;
    logic [IDX_W-1:0]       w_err_layer_next;
    logic [CNT_W-1:0]       w_last_next;

    logic [CNT_W-1:0]       w_cyc_cnt;
    logic                   w_expired;
    logic                   w_layer_hit;

    lenet_layer_wdog #(
        .CNT_W (CNT_W)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state != S_RUN),
        .i_run     (r_state == S_RUN),
        .i_limit   (TIMEOUT),
        .o_cnt     (w_cyc_cnt),
        .o_expired (w_expired)
    );

    // Only the active layer's finish flag matters; stale flags elsewhere are ignored.
    assign w_layer_hit = layer_done[r_cur_layer];

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_next     = r_state;
        w_rst_cnt_next   = r_rst_cnt;
        w_cur_next       = r_cur_layer;
        w_done_next      = 1'b0;
        w_error_next     = r_error;
        w_err_layer_next = r_err_layer;
        w_last_next      = r_last_cycles;

        if (abort && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (start && !abort) begin
                        w_state_next   = S_CLR;
                        w_cur_next     = FIRST_IDX;
                        w_rst_cnt_next = '0;
                        w_error_next   = 1'b0;
                    end
                end
                S_CLR: begin
                    if (r_rst_cnt == RST_LAST) begin
                        w_state_next = S_RUN;
                    end else begin
                        w_rst_cnt_next = r_rst_cnt + RST_W'(1);
                    end
                end
                S_RUN: begin
                    // Completion is checked before the watchdog so a tie counts as done.
                    if (w_layer_hit) begin
                        w_last_next  = w_cyc_cnt;
                        w_state_next = (r_cur_layer == LAST_IDX) ? S_DONE : S_GAP;
                    end else if (w_expired) begin
                        w_state_next     = S_ERR;
                        w_error_next     = 1'b1;
                        w_err_layer_next = r_cur_layer;
                        w_cur_next       = '0;
                    end
                end
                S_GAP: begin
                    w_state_next   = S_CLR;
                    w_cur_next     = r_cur_layer + IDX_W'(1);
                    w_rst_cnt_next = '0;
                end
                S_DONE: begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register alongside it.
        w_sel_next       = {{(NUM_LAYERS-1){1'b0}}, 1'b1} << w_cur_next;
        w_layer_rst_next = (w_state_next == S_CLR) ? w_sel_next : '0;
        w_layer_en_next  = (w_state_next == S_RUN) ? w_sel_next : '0;
        w_busy_next      = (w_state_next == S_CLR) || (w_state_next == S_RUN) ||
                           (w_state_next == S_GAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rst_cnt     <= '0;
            r_cur_layer   <= '0;
            r_layer_en    <= '0;
            r_layer_rst   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_err_layer   <= '0;
            r_last_cycles <= '0;
        end else begin
            r_state       <= w_state_next;
            r_rst_cnt     <= w_rst_cnt_next;
            r_cur_layer   <= w_cur_next;
            r_layer_en    <= w_layer_en_next;
            r_layer_rst   <= w_layer_rst_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_error       <= w_error_next;
            r_err_layer   <= w_err_layer_next;
            r_last_cycles <= w_last_next;
        end
    end

    assign layer_en    = r_layer_en;
    assign layer_rst   = r_layer_rst;
    assign cur_layer   = r_cur_layer;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign err_layer   = r_err_layer;
    assign last_cycles = r_last_cycles;

endmodule

// File: doc/lenet_layer_seq.md
Name: lenet_layer_seq

Overview:
- Top-level layer scheduler for the LeNet accelerator.
- Sequences the per-layer engines in fixed order: conv_1, pool_1, conv_2, pool_2, fc.
- Each engine has a level enable input and a sticky finish output that only a reset clears. The sequencer issues a per-layer reset, holds the layer's enable until its finish is seen, then moves to the next layer.
- Also provides a per-layer cycle count, a watchdog timeout and an abort.

Parameters:
- NUM_LAYERS, 5, number of sequenced layers; index 0 runs first.
- IDX_W, 3, width of the layer index; must satisfy 2^IDX_W >= NUM_LAYERS.
- RST_CYCLES, 2, number of cycles each layer_rst is held high before that layer is enabled (minimum 1).
- CNT_W, 20, width of the per-layer cycle counter and the watchdog.
- TIMEOUT, 20'hF_FFFF, watchdog limit in cycles of RUN for a single layer.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, one-cycle pulse that begins a full network pass.
- abort, input, 1, pulse that stops the pass immediately.
- layer_done, input, NUM_LAYERS, sticky finish flag from each layer.
- layer_en, output, NUM_LAYERS, level enable; one-hot or zero.
- layer_rst, output, NUM_LAYERS, per-layer synchronous reset; one-hot or zero.
- cur_layer, output, IDX_W, index of the active layer.
- busy, output, 1, high in CLR, RUN and GAP.
- done, output, 1, one-cycle pulse when the pass completes.
- error, output, 1, sticky watchdog flag.
- err_layer, output, IDX_W, index of the layer that timed out.
- last_cycles, output, CNT_W, RUN-cycle count of the most recently finished layer.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; layer_en = 0, layer_rst = 0, cur_layer = 0, busy = 0, done = 0, error = 0, err_layer = 0, last_cycles = 0.
- States: IDLE, CLR, RUN, GAP, DONE, ERR.
- IDLE:
  - start -> CLR with cur_layer = 0 and rst_cnt = 0.
  - error is cleared on this transition.
- CLR:
  - layer_rst[cur_layer] = 1 and layer_en = 0.
  - After RST_CYCLES cycles -> RUN.
  - layer_rst drops in the same cycle that layer_en[cur_layer] rises, so the engine sees a clean enable rising edge.
- RUN:
  - layer_en[cur_layer] = 1; cyc_cnt increments by 1 per cycle, starting from 0.
  - layer_done is sampled only for index cur_layer; other bits are ignored.
  - Normal completion: on layer_done[cur_layer] = 1, last_cycles <= cyc_cnt and layer_en <= 0.
    - If cur_layer == NUM_LAYERS-1 -> DONE.
    - Otherwise -> GAP.
  - Timeout: if cyc_cnt == TIMEOUT with done still low -> ERR; error <= 1, err_layer <= cur_layer, layer_en <= 0.
  - If done and timeout occur in the same cycle, done wins.
- GAP:
  - One cycle with all enables low; cur_layer increments.
  - -> CLR for the next layer.
- DONE:
  - done = 1 for exactly one cycle, then -> IDLE.
  - cur_layer holds NUM_LAYERS-1 until the next start.
- ERR:
  - error stays high; all outputs are low except error and err_layer.
  - start -> CLR at layer 0 and clears error; any other input is ignored.
- abort, in any state other than IDLE:
  - Next cycle: state IDLE, layer_en = 0, layer_rst = 0, no done pulse.
  - error is left unchanged.
  - abort has priority over every other transition.
- start while busy is ignored; start in the same cycle as abort is ignored.
- Latency:
  - start to layer_en[0] high is 1 + RST_CYCLES cycles.
  - Layer i done to layer_en[i+1] high is 2 + RST_CYCLES cycles.
  - The last layer's done to the done pulse is 2 cycles.
- cyc_cnt saturates at its maximum value; it cannot wrap because timeout fires first.
- rst asserted mid-pass returns the block to IDLE with reset values on the next edge.

Decomposition:
- Shared package lenet_pkg holds:
  - layer index constants: L_CONV1 = 0, L_POOL1 = 1, L_CONV2 = 2, L_POOL2 = 3, L_FC = 4;
  - NUM_LAYERS;
  - the state enum typedef.
- One natural sub-module: lenet_layer_wdog, containing the cycle counter, the saturation logic and the timeout compare. It takes clear, run and limit inputs and produces cnt and expired outputs.
- The FSM and the one-hot decode stay in the top module.

Test Plan:
- Nominal pass, RST_CYCLES = 2: pulse start at t0; layer models raise done after 10, 20, 30, 40, 50 RUN cycles.
  - layer_en[0] rises at t0+3.
  - Enables are one-hot and strictly ordered 0 -> 4.
  - last_cycles reads 10, 20, 30, 40, 50 in turn.
  - done pulses once, 2 cycles after layer 4's done; busy then falls.
- Stale done masking: hold layer_done = 5'b11111 before start, with models that clear done on layer_rst.
  - Each layer still receives its layer_rst pulse before its enable.
  - No layer is skipped.
- Watchdog, TIMEOUT = 100: layer 3 never raises done.
  - ERR entered exactly 101 RUN cycles after layer_en[3] rises.
  - error = 1, err_layer = 3, layer_en = 0.
  - A following start clears error and restarts at layer 0.
- Abort mid-layer: pulse abort while layer 2 is in RUN.
  - Next cycle: layer_en = 0, busy = 0, no done pulse.
  - A start issued 3 cycles later restarts at layer 0.
- Start while busy and simultaneous events:
  - A start pulse during layer 1 has no effect.
  - done and timeout in the same cycle -> GAP, error stays 0.
  - start together with abort in IDLE -> remains IDLE.
- Reset mid-pass: assert rst during CLR of layer 1.
  - Next edge: all outputs at their reset values.
  - A subsequent start runs a clean full pass.
